// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU and a
// single req/ready memory port, resolves branches from ALU flags, optionally
// dispatches M-extension ops to an external multi-cycle unit, and traps or
// skips illegal instructions.
module multicycle_controller #(
   parameter bit ENABLE_M        = 1'b1,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       funct7b0,
   input  logic       Zero,
   input  logic       Neg,
   input  logic       Carry,
   input  logic       Ovf,
   input  logic       mem_ready,
   input  logic       md_done,
   output logic       mem_req,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       md_start,
   output logic       instr_retired,
   output logic       illegal_instr
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [4:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB,
      S_UPPER, S_MULDIV, S_MDWB, S_TRAP
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_in_muldiv;   // already spent at least one cycle in MULDIV
   logic   w_illegal;
   logic   w_take;

   // funct7[5] only steers the ALU decoder, never the sequencing.
   logic   w_unused_f7b5;
   assign w_unused_f7b5 = funct7b5;

   // State register and MULDIV entry tracker.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_FETCH;
         r_in_muldiv <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_muldiv <= (r_state == S_MULDIV);
      end
   end

   // Classify the instruction held in the IR as legal or illegal.
   always_comb begin
      w_illegal = 1'b0;
      case (op)
         OP_LOAD, OP_STORE, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_illegal = 1'b0;
         OP_R:      w_illegal = funct7b0 && !ENABLE_M;
         OP_BRANCH: w_illegal = (funct3[2:1] == 2'b01);
         default:   w_illegal = 1'b1;
      endcase
   end

   // Branch condition from the A-B flags (Carry=1 means no borrow).
   always_comb begin
      w_take = 1'b0;
      case (funct3)
         3'b000:  w_take = Zero;
         3'b001:  w_take = !Zero;
         3'b100:  w_take = Neg ^ Ovf;
         3'b101:  w_take = !(Neg ^ Ovf);
         3'b110:  w_take = !Carry;
         3'b111:  w_take = Carry;
         default: w_take = 1'b0;
      endcase
   end

   // Next-state and control decode; everything held at zero during reset.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      w_next        = r_state;
      mem_req       = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      ImmSrc        = 3'b000;
      md_start      = 1'b0;
      instr_retired = 1'b0;
      illegal_instr = 1'b0;
      if (reset_n) begin
         case (r_state)
            S_FETCH: begin
               mem_req   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
               if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
               ImmSrc  = 3'b010;
               if (w_illegal) begin
                  if (TRAP_ON_ILLEGAL) begin
                     w_next = S_TRAP;
                  end else begin
                     w_next        = S_FETCH;
                     instr_retired = 1'b1;
                  end
               end else begin
                  case (op)
                     OP_LOAD, OP_STORE: w_next = S_MEMADR;
                     OP_R:              w_next = S_EXECR;
                     OP_I:              w_next = S_EXECI;
                     OP_BRANCH:         w_next = S_BRANCH;
                     OP_JAL:            w_next = S_JAL;
                     OP_JALR:           w_next = S_JALR;
                     default:           w_next = S_UPPER;
                  endcase
               end
            end
            S_MEMADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ImmSrc  = op[5] ? 3'b001 : 3'b000;
               w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
               if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
               ResultSrc     = 2'b01;
               RegWrite      = 1'b1;
               instr_retired = 1'b1;
               w_next        = S_FETCH;
            end
            S_MEMWRITE: begin
               mem_req       = 1'b1;
               AdrSrc        = 1'b1;
               MemWrite      = 1'b1;
               instr_retired = mem_ready;
               if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b10;
               w_next  = (ENABLE_M && funct7b0) ? S_MULDIV : S_ALUWB;
            end
            S_EXECI: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ALUOp   = 2'b10;
               w_next  = S_ALUWB;
            end
            S_ALUWB: begin
               RegWrite      = 1'b1;
               instr_retired = 1'b1;
               w_next        = S_FETCH;
            end
            S_BRANCH: begin
               ALUSrcA       = 2'b10;
               ALUOp         = 2'b01;
               PCWrite       = w_take;
               instr_retired = 1'b1;
               w_next        = S_FETCH;
            end
            S_JAL: begin
               ImmSrc  = 3'b011;
               PCWrite = 1'b1;
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               w_next  = S_ALUWB;
            end
            S_JALR: begin
               ALUSrcA   = 2'b10;
               ALUSrcB   = 2'b01;
               ResultSrc = 2'b10;
               PCWrite   = 1'b1;
               w_next    = S_JALRWB;
            end
            S_JALRWB: begin
               ALUSrcA       = 2'b01;
               ALUSrcB       = 2'b10;
               ResultSrc     = 2'b10;
               RegWrite      = 1'b1;
               instr_retired = 1'b1;
               w_next        = S_FETCH;
            end
            S_UPPER: begin
               ImmSrc        = 3'b100;
               ALUSrcB       = 2'b01;
               ALUSrcA       = op[5] ? 2'b11 : 2'b01;
               ResultSrc     = 2'b10;
               RegWrite      = 1'b1;
               instr_retired = 1'b1;
               w_next        = S_FETCH;
            end
            S_MULDIV: begin
               md_start = !r_in_muldiv;
               if (md_done) w_next = S_MDWB;
            end
            S_MDWB: begin
               ResultSrc     = 2'b11;
               RegWrite      = 1'b1;
               instr_retired = 1'b1;
               w_next        = S_FETCH;
            end
            S_TRAP: begin
               illegal_instr = 1'b1;
            end
            default: w_next = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: three instances cover the
// parameter corners; an instruction-level reference model expands each
// instruction into its expected per-cycle control vectors.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // instance 0: M on, trap on; 1: M off, trap on; 2: M on, trap off
   localparam logic [2:0] EN_M = 3'b101;
   localparam logic [2:0] TRAP = 3'b011;

   typedef struct packed {
      logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
      logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
      logic [2:0] imm_src;
      logic       md_start, retired, illegal;
   } ctl_t;

   logic       clk = 1'b0;
   logic [2:0] rst_n = 3'b000;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0, funct7b0 = 1'b0;
   logic       zero = 1'b0, neg = 1'b0, carry = 1'b0, ovf = 1'b0;
   logic       mem_ready = 1'b0, md_done = 1'b0;
   ctl_t       obs [3];
   int         cur = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
      logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
      logic [2:0] ImmSrc;
      logic md_start, instr_retired, illegal_instr;
      multicycle_controller #(
         .ENABLE_M(EN_M[g]), .TRAP_ON_ILLEGAL(TRAP[g])
      ) u_dut (
         .clk(clk), .reset_n(rst_n[g]), .op(op), .funct3(funct3),
         .funct7b5(funct7b5), .funct7b0(funct7b0),
         .Zero(zero), .Neg(neg), .Carry(carry), .Ovf(ovf),
         .mem_ready(mem_ready), .md_done(md_done),
         .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
         .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
         .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
         .ALUOp(ALUOp), .ImmSrc(ImmSrc), .md_start(md_start),
         .instr_retired(instr_retired), .illegal_instr(illegal_instr)
      );
      assign obs[g] = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
                       md_start, instr_retired, illegal_instr};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called at posedge+1: let inputs settle, compare, advance one cycle.
   task automatic step(input string tag, input ctl_t e);
      #2;
      check($sformatf("d%0d %s", cur, tag), {12'b0, obs[cur]}, {12'b0, e});
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset mid-cycle: outputs must drop at once and stay low.
   task automatic do_reset(input int d);
      cur = d;
      rst_n[d] = 1'b0;
      #1;
      check($sformatf("d%0d rst_async", d), {12'b0, obs[d]}, 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("d%0d rst_hold", d), {12'b0, obs[d]}, 32'h0);
      rst_n[d] = 1'b1;
   endtask

   task automatic alu_wb();
      ctl_t e;
      e = '0;
      e.reg_write = 1'b1;
      e.retired   = 1'b1;
      step("aluwb", e);
   endtask

   // Reference model: runs one instruction on instance cur with the given
   // memory/mul-div wait counts; branch flags come from real operands a, b.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7b0,
                            input logic [31:0] a, input logic [31:0] b,
                            input int fw, input int mw, input int mdw, input bit abort_mem);
      ctl_t        e;
      logic [31:0] diff;
      bit          ill;
      bit          take;
      bit          en_m;
      bit          trap;
      en_m = EN_M[cur];
      trap = TRAP[cur];
      diff = a - b;
      op = o; funct3 = f3; funct7b0 = f7b0; funct7b5 = 1'($urandom);
      zero = (a == b);
      neg = diff[31];
      carry = (a >= b);
      ovf = (a[31] != b[31]) && (diff[31] != a[31]);
      case (f3)
         3'b000:  take = (a == b);
         3'b001:  take = (a != b);
         3'b100:  take = ($signed(a) < $signed(b));
         3'b101:  take = ($signed(a) >= $signed(b));
         3'b110:  take = (a < b);
         3'b111:  take = (a >= b);
         default: take = 1'b0;
      endcase
      md_done = 1'b0;

      for (int k = 0; k <= fw; k++) begin
         mem_ready = (k == fw);
         e = '0;
         e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
         e.ir_write = mem_ready; e.pc_write = mem_ready;
         step("fetch", e);
      end
      mem_ready = 1'b0;

      case (o)
         OP_LOAD, OP_STORE, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_R: ill = 1'b0;
         default: ill = 1'b1;
      endcase
      if (o == OP_BRANCH && (f3 == 3'b010 || f3 == 3'b011)) ill = 1'b1;
      if (o == OP_R && f7b0 && !en_m) ill = 1'b1;

      e = '0;
      e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.imm_src = 3'b010;
      if (ill) begin
         if (!trap) begin
            e.retired = 1'b1;
            step("decode_nop", e);
            return;
         end
         step("decode_ill", e);
         for (int k = 0; k < 3; k++) begin
            mem_ready = 1'($urandom);
            md_done = 1'($urandom);
            e = '0;
            e.illegal = 1'b1;
            step("trap", e);
         end
         mem_ready = 1'b0; md_done = 1'b0;
         do_reset(cur);
         return;
      end
      step("decode", e);

      case (o)
         OP_LOAD, OP_STORE: begin
            e = '0;
            e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
            e.imm_src = o[5] ? 3'b001 : 3'b000;
            step("memadr", e);
            for (int k = 0; k <= mw; k++) begin
               mem_ready = (k == mw);
               e = '0;
               e.mem_req = 1'b1; e.adr_src = 1'b1;
               if (o[5]) begin
                  e.mem_write = 1'b1;
                  e.retired = mem_ready;
               end
               step(o[5] ? "memwrite" : "memread", e);
               if (abort_mem && k == 0) begin
                  mem_ready = 1'b0;
                  do_reset(cur);
                  return;
               end
            end
            mem_ready = 1'b0;
            if (!o[5]) begin
               e = '0;
               e.result_src = 2'b01; e.reg_write = 1'b1; e.retired = 1'b1;
               step("memwb", e);
            end
         end
         OP_R: begin
            e = '0;
            e.alu_src_a = 2'b10; e.alu_op = 2'b10;
            step("execr", e);
            if (f7b0) begin
               for (int k = 0; k <= mdw; k++) begin
                  md_done = (k == mdw);
                  e = '0;
                  e.md_start = (k == 0);
                  step("muldiv", e);
               end
               md_done = 1'b0;
               e = '0;
               e.result_src = 2'b11; e.reg_write = 1'b1; e.retired = 1'b1;
               step("mdwb", e);
            end else begin
               alu_wb();
            end
         end
         OP_I: begin
            e = '0;
            e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10;
            step("execi", e);
            alu_wb();
         end
         OP_BRANCH: begin
            e = '0;
            e.alu_src_a = 2'b10; e.alu_op = 2'b01;
            e.pc_write = take; e.retired = 1'b1;
            step($sformatf("branch f3=%0d", f3), e);
         end
         OP_JAL: begin
            e = '0;
            e.imm_src = 3'b011; e.pc_write = 1'b1;
            e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
            step("jal", e);
            alu_wb();
         end
         OP_JALR: begin
            e = '0;
            e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
            e.result_src = 2'b10; e.pc_write = 1'b1;
            step("jalr", e);
            e = '0;
            e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
            e.result_src = 2'b10; e.reg_write = 1'b1; e.retired = 1'b1;
            step("jalrwb", e);
         end
         default: begin
            e = '0;
            e.imm_src = 3'b100; e.alu_src_b = 2'b01;
            e.alu_src_a = o[5] ? 2'b11 : 2'b01;
            e.result_src = 2'b10; e.reg_write = 1'b1; e.retired = 1'b1;
            step("upper", e);
         end
      endcase
   endtask

   logic [6:0] valid_ops [9];

   initial begin
      logic [6:0]  o;
      logic [31:0] a, b;
      valid_ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

      @(posedge clk);
      #1;
      do_reset(0);

      // directed scenarios on the fully featured instance
      run_instr(OP_I, 3'b000, 1'b0, 0, 0, 3, 0, 0, 1'b0);
      run_instr(OP_BRANCH, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1'b0);
      run_instr(OP_BRANCH, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1'b0);
      run_instr(OP_BRANCH, 3'b000, 1'b0, 32'h1234, 32'h1234, 1, 0, 0, 1'b0);
      run_instr(OP_STORE, 3'b010, 1'b0, 0, 0, 0, 2, 0, 1'b0);
      run_instr(OP_LOAD, 3'b010, 1'b0, 0, 0, 0, 1, 0, 1'b0);
      run_instr(OP_R, 3'b000, 1'b1, 0, 0, 0, 0, 5, 1'b0);
      run_instr(OP_R, 3'b000, 1'b1, 0, 0, 0, 0, 0, 1'b0);
      run_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      run_instr(OP_LUI, 3'b000, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      run_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      run_instr(OP_STORE, 3'b010, 1'b0, 0, 0, 0, 2, 0, 1'b1);
      run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      run_instr(OP_BRANCH, 3'b010, 1'b0, 0, 0, 0, 0, 0, 1'b0);

      // M disabled: mul traps
      do_reset(1);
      run_instr(OP_R, 3'b000, 1'b1, 0, 0, 0, 0, 2, 1'b0);
      run_instr(OP_R, 3'b000, 1'b0, 0, 0, 0, 0, 0, 1'b0);

      // trap disabled: illegal retires as a NOP
      do_reset(2);
      run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      run_instr(OP_I, 3'b000, 1'b0, 0, 0, 0, 0, 0, 1'b0);

      // randomized instruction streams on every instance
      for (int d = 0; d < 3; d++) begin
         do_reset(d);
         for (int i = 0; i < 150; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 9) o = 7'($urandom) & 7'b1111100;
            else          o = valid_ops[sel];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(o, 3'($urandom), 1'($urandom), a, b,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), ($urandom_range(0, 19) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
